// File: rtl/pcla_adder.sv
// rtl/pcla_adder.sv - pipelined carry-lookahead adder/subtractor, one 4-bit group per stage
//
// Purpose : z = x + y + cin (sub=0) or z = x - y (sub=1), WIDTH bits wide,
//           processed one 4-bit lookahead group per pipeline stage with the
//           group carry registered between stages. Full throughput with a
//           single global advance enable shared by every stage.
// Params  : WIDTH  operand/result width, multiple of 4 and >= 4
//           STAGES WIDTH/4 (derived)
// Ports   : clk, rst_n (sync, active-low)
//           in_valid/in_ready    operand handshake; sub, cin, x, y sampled on transfer
//           out_valid/out_ready  result handshake; z, cout, ovf from last-stage register
// Macro   : PCLA_SAT_EN - signed saturation of z when ovf=1 (flags unchanged)
module pcla_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / 4;

   logic             adv;
   logic [WIDTH-1:0] yi;
   logic             c0;

   // Whole pipeline moves together; stalls only when a result is waiting.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign yi       = sub ? ~y : y;
   assign c0       = sub | cin;

   // 4-bit lookahead group: returns {carry_out, sum[3:0]}, every carry in
   // two-level form so nothing ripples inside the group.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
      logic [3:0] g, p, cv;
      logic       c4;
      g     = a & b;
      p     = a ^ b;
      cv[0] = c;
      cv[1] = g[0] | (p[0] & c);
      cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      return {c4, p ^ cv};
   endfunction

   for (genvar j = 0; j < STAGES; j++) begin : g_stage
      localparam int SW = 4 * (j + 1);     // sum bits accumulated after this stage
      localparam int OW = WIDTH - 4 * j;   // operand bits not yet consumed on entry

      logic          v_in, c_in;
      logic [OW-1:0] x_src, y_src;
      logic [SW-1:0] sum_d, sum_n;
      logic [4:0]    grp;
      logic          v_q, c_q;
      logic [SW-1:0] sum_q;

      // Operands are forwarded shifted down, so the current group is always bits [3:0].
      assign grp = cla4(x_src[3:0], y_src[3:0], c_in);

      if (j == 0) begin : g_src
         assign v_in  = in_valid;
         assign x_src = x;
         assign y_src = yi;
         assign c_in  = c0;
         assign sum_d = grp[3:0];
      end else begin : g_src
         assign v_in  = g_stage[j-1].v_q;
         assign x_src = g_stage[j-1].g_fwd.x_q;
         assign y_src = g_stage[j-1].g_fwd.y_q;
         assign c_in  = g_stage[j-1].c_q;
         assign sum_d = {grp[3:0], g_stage[j-1].sum_q};
      end

      if (j < STAGES - 1) begin : g_fwd
         logic [OW-5:0] x_q, y_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               x_q <= '0;
               y_q <= '0;
            end else if (adv) begin
               x_q <= x_src[OW-1:4];
               y_q <= y_src[OW-1:4];
            end
         end
         assign sum_n = sum_d;
      end else begin : g_last
         logic c_msb;
         logic ovf_d;
         logic ovf_q;
         // Carry into the MSB recovered from its sum bit: s3 = p3 ^ c3.
         assign c_msb = grp[3] ^ x_src[3] ^ y_src[3];
         assign ovf_d = c_msb ^ grp[4];
`ifdef PCLA_SAT_EN
         // x_src[3] is x[WIDTH-1], forwarded with the unconsumed operand bits.
         always_comb begin
            sum_n = sum_d;
            if (ovf_d) begin
               sum_n = x_src[3] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
            end
         end
`else
         assign sum_n = sum_d;
`endif
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_d;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            sum_q <= '0;
            c_q   <= 1'b0;
         end else if (adv) begin
            v_q   <= v_in;
            sum_q <= sum_n;
            c_q   <= grp[4];
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign z         = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
